// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register file write port between an ALU and a long-latency unit
// Tracks registers reserved for the long-latency port and reports read hazards to decode.
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter bit ZERO_R0  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic        a_fpoint,
    input  logic [4:0]  a_dst,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic        b_fpoint,
    input  logic [4:0]  b_dst,
    input  logic [31:0] b_data,
    input  logic        iss_valid,
    output logic        iss_ready,
    input  logic        iss_fpoint,
    input  logic [4:0]  iss_dst,
    input  logic        q_fpoint,
    input  logic [4:0]  q_rs,
    input  logic [4:0]  q_rt,
    output logic        hazard_a,
    output logic        hazard_b,
    output logic        rf_write,
    output logic        rf_regdst,
    output logic        rf_fpoint,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_busW
);

    localparam int AW = $clog2(MAX_WAIT + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(MAX_WAIT);

    logic [AW-1:0] age;
    logic [63:0]   pending;
    logic          rf_from_b;

    logic          b_wins;
    logic          grant;
    logic          win_fp;
    logic [4:0]    win_dst;
    logic [31:0]   win_data;
    logic          win_write;
    logic          iss_set;

    assign rf_regdst = 1'b1;

    always_comb begin
        b_wins    = b_valid && ((age == AGE_MAX) || !a_valid);
        a_ready   = a_valid && !b_wins;
        b_ready   = b_valid && b_wins;
        grant     = a_ready || b_ready;
        win_fp    = b_wins ? b_fpoint : a_fpoint;
        win_dst   = b_wins ? b_dst    : a_dst;
        win_data  = b_wins ? b_data   : a_data;
        // Integer r0 is hardwired: the handshake completes but nothing is written.
        win_write = grant && !(ZERO_R0 && !win_fp && (win_dst == 5'd0));
        // A pending bit stays set through its clearing cycle, which also rules out set/clear collisions.
        iss_ready = iss_valid && !pending[{iss_fpoint, iss_dst}];
        iss_set   = iss_ready && !(ZERO_R0 && !iss_fpoint && (iss_dst == 5'd0));
        hazard_a  = pending[{q_fpoint, q_rs}];
        hazard_b  = pending[{q_fpoint, q_rt}];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age <= '0;
        end else if (b_valid && !b_ready) begin
            if (age != AGE_MAX) age <= age + 1'b1;
        end else begin
            age <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_write  <= 1'b0;
            rf_from_b <= 1'b0;
            rf_fpoint <= 1'b0;
            rf_rd     <= 5'd0;
            rf_busW   <= 32'd0;
        end else begin
            rf_write  <= win_write;
            rf_from_b <= b_ready;
            if (grant) begin
                rf_fpoint <= win_fp;
                rf_rd     <= win_dst;
                rf_busW   <= win_data;
            end
        end
    end

    // The reservation is released on the same edge the register file commits the B value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (rf_write && rf_from_b) pending[{rf_fpoint, rf_rd}] <= 1'b0;
            if (iss_set) pending[{iss_fpoint, iss_dst}] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, a_ready, a_fpoint;
    logic [4:0]  a_dst;
    logic [31:0] a_data;
    logic        b_valid, b_ready, b_fpoint;
    logic [4:0]  b_dst;
    logic [31:0] b_data;
    logic        iss_valid, iss_ready, iss_fpoint;
    logic [4:0]  iss_dst;
    logic        q_fpoint;
    logic [4:0]  q_rs, q_rt;
    logic        hazard_a, hazard_b;
    logic        rf_write, rf_regdst, rf_fpoint;
    logic [4:0]  rf_rd;
    logic [31:0] rf_busW;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.MAX_WAIT(4), .ZERO_R0(1'b1)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_fpoint(a_fpoint), .a_dst(a_dst), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_fpoint(b_fpoint), .b_dst(b_dst), .b_data(b_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_fpoint(iss_fpoint), .iss_dst(iss_dst),
        .q_fpoint(q_fpoint), .q_rs(q_rs), .q_rt(q_rt),
        .hazard_a(hazard_a), .hazard_b(hazard_b),
        .rf_write(rf_write), .rf_regdst(rf_regdst), .rf_fpoint(rf_fpoint),
        .rf_rd(rf_rd), .rf_busW(rf_busW)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Test 1 vectors: expected winner dst per cycle (A loses cycle 4 and re-presents dst 5 in cycle 5)
    logic [4:0] a_dst_v  [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd5};
    logic [4:0] b_dst_v  [6] = '{5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 5'd10};
    logic [4:0] win_v    [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd5};

    initial begin
        reset = 1'b1;
        a_valid = 0; a_fpoint = 0; a_dst = 0; a_data = 0;
        b_valid = 0; b_fpoint = 0; b_dst = 0; b_data = 0;
        iss_valid = 0; iss_fpoint = 0; iss_dst = 0;
        q_fpoint = 0; q_rs = 0; q_rt = 0;
        #2;
        check("rst_rf_write", rf_write, 0);
        check("rst_rf_regdst", rf_regdst, 1);
        check("rst_rf_rd", rf_rd, 0);
        check("rst_rf_busW", rf_busW, 0);
        check("rst_hazard_a", hazard_a, 0);
        step(); step();
        reset = 1'b0;

        // 1. arbitration aging with both producers busy
        for (int c = 0; c < 6; c++) begin
            step();
            a_valid = 1; a_fpoint = 0; a_dst = a_dst_v[c]; a_data = 32'(100 + c);
            b_valid = 1; b_fpoint = 0; b_dst = b_dst_v[c]; b_data = 32'hB0B0_0000 + 32'(c);
            #1;
            check($sformatf("t1_a_ready_c%0d", c), a_ready, (c != 4) ? 1 : 0);
            check($sformatf("t1_b_ready_c%0d", c), b_ready, (c == 4) ? 1 : 0);
            if (c > 0) begin
                check($sformatf("t1_rf_write_c%0d", c), rf_write, 1);
                check($sformatf("t1_rf_rd_c%0d", c), rf_rd, 32'(win_v[c-1]));
            end
        end
        step();
        a_valid = 0; b_valid = 0;
        #1;
        check("t1_rf_rd_last", rf_rd, 5);
        check("t1_rf_busW_last", rf_busW, 105);
        step();
        check("t1_idle_rf_write", rf_write, 0);
        check("t1_idle_rf_rd_hold", rf_rd, 5);

        // 2. fp5 reservation, hazard, writeback
        iss_valid = 1; iss_fpoint = 1; iss_dst = 5;
        #1;
        check("t2_iss_ready", iss_ready, 1);
        step();
        iss_valid = 0; q_fpoint = 1; q_rs = 5; q_rt = 6;
        #1;
        check("t2_hazard_a", hazard_a, 1);
        check("t2_hazard_b", hazard_b, 0);
        step();
        b_valid = 1; b_fpoint = 1; b_dst = 5; b_data = 32'hDEADBEEF;
        #1;
        check("t2_b_ready", b_ready, 1);
        check("t2_hazard_N", hazard_a, 1);
        step();
        b_valid = 0;
        #1;
        check("t2_rf_write", rf_write, 1);
        check("t2_rf_fpoint", rf_fpoint, 1);
        check("t2_rf_rd", rf_rd, 5);
        check("t2_rf_busW", rf_busW, 32'hDEADBEEF);
        check("t2_hazard_N1", hazard_a, 1);
        step();
        check("t2_hazard_N2", hazard_a, 0);
        check("t2_rf_write_N2", rf_write, 0);

        // 3. WAW stall on int7
        iss_valid = 1; iss_fpoint = 0; iss_dst = 7;
        #1;
        check("t3_iss_first", iss_ready, 1);
        step();
        check("t3_iss_stall", iss_ready, 0);
        b_valid = 1; b_fpoint = 0; b_dst = 7; b_data = 77;
        #1;
        check("t3_b_ready", b_ready, 1);
        check("t3_iss_stall_N", iss_ready, 0);
        step();
        b_valid = 0;
        #1;
        check("t3_iss_stall_N1", iss_ready, 0);
        check("t3_rf_rd", rf_rd, 7);
        step();
        check("t3_iss_ready_N2", iss_ready, 1);
        step();
        iss_valid = 0; q_fpoint = 0; q_rs = 7; q_rt = 0;
        #1;
        check("t3_reissued_hazard", hazard_a, 1);

        // 4. int r0 write is dropped
        a_valid = 1; a_fpoint = 0; a_dst = 0; a_data = 32'h1234;
        #1;
        check("t4_a_ready", a_ready, 1);
        step();
        a_valid = 0;
        #1;
        check("t4_rf_write", rf_write, 0);
        check("t4_int7_still", hazard_a, 1);
        check("t4_r0_clear", hazard_b, 0);

        // 5. reset between grant and commit, with fp3 reserved
        b_valid = 1; b_fpoint = 0; b_dst = 7; b_data = 55;
        iss_valid = 1; iss_fpoint = 1; iss_dst = 3;
        #1;
        check("t5_b_ready", b_ready, 1);
        step();
        b_valid = 0; iss_valid = 0; q_fpoint = 1; q_rs = 3;
        #1;
        check("t5_rf_write_pre", rf_write, 1);
        check("t5_fp3_hazard_pre", hazard_a, 1);
        reset = 1;
        #1;
        check("t5_rf_write_async", rf_write, 0);
        check("t5_rf_busW_async", rf_busW, 0);
        check("t5_fp3_hazard_post", hazard_a, 0);
        q_fpoint = 0; q_rt = 7;
        #1;
        check("t5_int7_hazard_post", hazard_b, 0);
        step();
        reset = 0;

        // 6. B alone streams back-to-back
        b_valid = 1; b_fpoint = 0; b_dst = 10; b_data = 1;
        #1;
        check("t6_b_ready0", b_ready, 1);
        step();
        b_dst = 11; b_data = 2;
        #1;
        check("t6_b_ready1", b_ready, 1);
        check("t6_rf_rd1", rf_rd, 10);
        check("t6_rf_busW1", rf_busW, 1);
        step();
        b_dst = 12; b_data = 3;
        #1;
        check("t6_b_ready2", b_ready, 1);
        check("t6_rf_rd2", rf_rd, 11);
        step();
        a_valid = 1; a_dst = 2; a_data = 9;
        b_dst = 13; b_data = 4;
        #1;
        check("t6_rf_rd3", rf_rd, 12);
        check("t6_age0_a_wins", a_ready, 1);
        check("t6_age0_b_waits", b_ready, 0);
        step();
        a_valid = 0; b_valid = 0;
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
